// File: rtl/rx_frame_guard.sv
// Frame guard between a UART receiver and a command decoder: buffers one frame, validates it, then forwards it.
// Optional checksum byte support is enabled by defining RX_GUARD_CHECKSUM_EN.
module rx_frame_guard #(
   parameter int N_SRC       = 25,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic [7:0] err_cnt
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [8:0] N_SRC_W = 9'(N_SRC);

`ifdef RX_GUARD_CHECKSUM_EN
   typedef enum logic [2:0] {S_ADDR = 3'd0, S_LEN = 3'd1, S_PAY = 3'd2, S_CSUM = 3'd3, S_DRAIN = 3'd4} state_t;
`else
   typedef enum logic [2:0] {S_ADDR = 3'd0, S_LEN = 3'd1, S_PAY = 3'd2, S_DRAIN = 3'd4} state_t;
`endif

   state_t        state_r, state_s;
   logic          in_ready_r, out_valid_r, frame_ok_r, frame_err_r;
   logic [7:0]    out_data_r, err_cnt_r, pay_left_r;
   logic [1:0]    err_code_r, code_s;
   logic          bad_r, ok_s, err_s, accept_s, data_acc_s, to_hit_s;
   logic [8:0]    wr_ptr_r, rd_ptr_r, total_r;
   logic [TW-1:0] to_cnt_r;
   logic [7:0]    buf_mem [0:256];
`ifdef RX_GUARD_CHECKSUM_EN
   logic [7:0]    csum_r;
`endif

   assign accept_s   = in_valid && in_ready_r;
   assign data_acc_s = accept_s && (state_r == S_ADDR || state_r == S_LEN || state_r == S_PAY);
   assign to_hit_s   = (to_cnt_r == TW'(TIMEOUT_CYC - 1));

   // Next-state decode and end-of-frame verdict
   always_comb begin
      state_s = state_r;
      ok_s    = 1'b0;
      err_s   = 1'b0;
      code_s  = 2'd0;
      case (state_r)
         S_ADDR: begin
            if (accept_s) state_s = S_LEN;
            else          state_s = S_ADDR;
         end
         S_LEN: begin
            if (accept_s) begin
               if (in_data == 8'd0) begin
`ifdef RX_GUARD_CHECKSUM_EN
                  state_s = S_CSUM;
`else
                  err_s   = 1'b1;
                  code_s  = 2'd1;
                  state_s = S_ADDR;
`endif
               end else begin
                  state_s = S_PAY;
               end
            end else if (to_hit_s) begin
               err_s   = 1'b1;
               code_s  = 2'd3;
               state_s = S_ADDR;
            end else begin
               state_s = S_LEN;
            end
         end
         S_PAY: begin
            if (accept_s) begin
               if (pay_left_r == 8'd1) begin
`ifdef RX_GUARD_CHECKSUM_EN
                  state_s = S_CSUM;
`else
                  if (bad_r) begin
                     err_s   = 1'b1;
                     code_s  = 2'd1;
                     state_s = S_ADDR;
                  end else begin
                     ok_s    = 1'b1;
                     state_s = S_DRAIN;
                  end
`endif
               end else begin
                  state_s = S_PAY;
               end
            end else if (to_hit_s) begin
               err_s   = 1'b1;
               code_s  = 2'd3;
               state_s = S_ADDR;
            end else begin
               state_s = S_PAY;
            end
         end
`ifdef RX_GUARD_CHECKSUM_EN
         S_CSUM: begin
            if (accept_s) begin
               // A bad address/length outranks a checksum mismatch
               if (bad_r) begin
                  err_s   = 1'b1;
                  code_s  = 2'd1;
                  state_s = S_ADDR;
               end else if (in_data != csum_r) begin
                  err_s   = 1'b1;
                  code_s  = 2'd2;
                  state_s = S_ADDR;
               end else begin
                  ok_s    = 1'b1;
                  state_s = S_DRAIN;
               end
            end else if (to_hit_s) begin
               err_s   = 1'b1;
               code_s  = 2'd3;
               state_s = S_ADDR;
            end else begin
               state_s = S_CSUM;
            end
         end
`endif
         S_DRAIN: begin
            if (out_valid_r && out_ready && rd_ptr_r == total_r) state_s = S_ADDR;
            else                                                 state_s = S_DRAIN;
         end
         default: state_s = S_ADDR;
      endcase
   end

   // Frame buffer storage; addr, len and payload only
   always_ff @(posedge clk) begin
      if (data_acc_s) buf_mem[wr_ptr_r] <= in_data;
   end

   // State, reception bookkeeping, drain sequencing and status outputs
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_r     <= S_ADDR;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= 8'd0;
         frame_ok_r  <= 1'b0;
         frame_err_r <= 1'b0;
         err_code_r  <= 2'd0;
         err_cnt_r   <= 8'd0;
         bad_r       <= 1'b0;
         pay_left_r  <= 8'd0;
         wr_ptr_r    <= 9'd0;
         rd_ptr_r    <= 9'd0;
         total_r     <= 9'd0;
         to_cnt_r    <= '0;
`ifdef RX_GUARD_CHECKSUM_EN
         csum_r      <= 8'd0;
`endif
      end else begin
         state_r     <= state_s;
         in_ready_r  <= (state_s != S_DRAIN);
         frame_ok_r  <= ok_s;
         frame_err_r <= err_s;
         if (err_s) begin
            err_code_r <= code_s;
            if (err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
         end
         if (accept_s || state_s == S_ADDR || state_s == S_DRAIN) to_cnt_r <= '0;
         else                                                     to_cnt_r <= to_cnt_r + TW'(1);

         if (state_s == S_ADDR) begin
            bad_r    <= 1'b0;
            wr_ptr_r <= 9'd0;
`ifdef RX_GUARD_CHECKSUM_EN
            csum_r   <= 8'd0;
`endif
         end else if (data_acc_s) begin
            wr_ptr_r <= wr_ptr_r + 9'd1;
`ifdef RX_GUARD_CHECKSUM_EN
            csum_r   <= csum_r ^ in_data;
`endif
            if (state_r == S_ADDR && {1'b0, in_data} >= N_SRC_W) bad_r <= 1'b1;
            if (state_r == S_LEN) begin
               pay_left_r <= in_data;
               total_r    <= {1'b0, in_data} + 9'd2;
               if (in_data == 8'd0) bad_r <= 1'b1;
            end
            if (state_r == S_PAY) pay_left_r <= pay_left_r - 8'd1;
         end

         // A new byte is loaded only once the previous one has been taken
         if (state_r == S_DRAIN) begin
            if (!out_valid_r || out_ready) begin
               if (rd_ptr_r == total_r) begin
                  out_valid_r <= 1'b0;
               end else begin
                  out_data_r  <= buf_mem[rd_ptr_r];
                  out_valid_r <= 1'b1;
                  rd_ptr_r    <= rd_ptr_r + 9'd1;
               end
            end
         end else begin
            out_valid_r <= 1'b0;
            rd_ptr_r    <= 9'd0;
         end
      end
   end

   assign in_ready  = in_ready_r;
   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
   assign frame_ok  = frame_ok_r;
   assign frame_err = frame_err_r;
   assign err_code  = err_code_r;
   assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_rx_frame_guard.sv
// Self-checking bench for rx_frame_guard: frame-level reference model, scoreboard monitor, directed frames.
// Works with or without RX_GUARD_CHECKSUM_EN defined.
module tb_rx_frame_guard;
   localparam int N_SRC = 25;
   localparam int TO    = 40;

   typedef logic [7:0] byte_q_t [$];

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       frame_ok, frame_err;
   logic [1:0] err_code;
   logic [7:0] err_cnt;

   int   n_checks = 0;
   int   n_errors = 0;
   bit   bp_mode = 1'b0;
   int   exp_cnt = 0;
   logic [1:0] exp_ev [$];
   logic [7:0] exp_out [$];

   always #5 clk = ~clk;

   rx_frame_guard #(.N_SRC(N_SRC), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .n_rst(n_rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .err_cnt(err_cnt)
   );

   function automatic void chk(input bit c, input string nm, input int act, input int exp_v);
      n_checks++;
      if (!c) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endfunction

   // Reference model: verdict (0 = forwarded, else err_code) and forwarded bytes of one whole frame
   function automatic void predict(input byte_q_t f, output logic [1:0] code, output byte_q_t outb);
      int len;
      logic [7:0] x;
      bit bad;
      outb = {};
      len  = int'(f[1]);
      bad  = (int'(f[0]) >= N_SRC) || (len == 0);
      x    = 8'h00;
      for (int i = 0; i < len + 2; i++) begin
         x ^= f[i];
         outb.push_back(f[i]);
      end
      if (bad) code = 2'd1;
`ifdef RX_GUARD_CHECKSUM_EN
      else if (f[len + 2] != x) code = 2'd2;
`endif
      else code = 2'd0;
   endfunction

   always @(posedge clk) begin
      #1;
      out_ready = bp_mode ? ~out_ready : 1'b1;
   end

   // Compare process: pulses, status, drain bytes and handshake rules
   logic [7:0] prev_data = 8'h00;
   bit   prev_stall = 1'b0;
   bit   ok_pend = 1'b0;
   int   ok_age = 0;
   always @(negedge clk) begin
      logic [1:0] ev;
      logic [7:0] eb;
      if (!n_rst) begin
         exp_cnt = 0;
         exp_ev.delete();
         exp_out.delete();
         prev_stall = 1'b0;
         ok_pend = 1'b0;
      end else begin
         chk(!(frame_ok && frame_err), "pulse_exclusive", int'(frame_ok), 0);
         if (frame_ok || frame_err) begin
            if (exp_ev.size() == 0) begin
               chk(1'b0, "unexpected_pulse", int'(frame_ok), -1);
            end else begin
               ev = exp_ev.pop_front();
               if (frame_ok) begin
                  chk(ev == 2'd0, "ok_vs_model", 0, int'(ev));
                  ok_pend = 1'b1;
                  ok_age = 0;
               end else begin
                  if (exp_cnt < 255) exp_cnt++;
                  chk(ev != 2'd0 && err_code == ev, "err_code", int'(err_code), int'(ev));
               end
               chk(err_cnt == exp_cnt[7:0], "err_cnt", int'(err_cnt), exp_cnt);
            end
         end else if (ok_pend) begin
            ok_age++;
         end
         if (out_valid) begin
            chk(in_ready == 1'b0, "in_ready_in_drain", int'(in_ready), 0);
            if (ok_pend) begin
               chk(ok_age <= 2, "first_valid_latency", ok_age, 2);
               ok_pend = 1'b0;
            end
            if (prev_stall) chk(out_data == prev_data, "stall_stable", int'(out_data), int'(prev_data));
            if (out_ready) begin
               if (exp_out.size() == 0) begin
                  chk(1'b0, "unexpected_byte", int'(out_data), -1);
               end else begin
                  eb = exp_out.pop_front();
                  chk(out_data == eb, "out_byte", int'(out_data), int'(eb));
               end
            end
         end else begin
            if (prev_stall) chk(1'b0, "valid_dropped_stalled", 0, 1);
            if (ok_pend && ok_age > 2) begin
               chk(1'b0, "first_valid_latency", ok_age, 2);
               ok_pend = 1'b0;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic send(input byte_q_t q);
      int k;
      bit rdy;
      foreach (q[i]) begin
         in_data  = q[i];
         in_valid = 1'b1;
         k = 0;
         do begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            k++;
         end while (!rdy && k < 3000);
         if (!rdy) begin
            chk(1'b0, "send_timeout", k, 3000);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic expect_frame(input byte_q_t f);
      logic [1:0] code;
      byte_q_t ob;
      predict(f, code, ob);
      exp_ev.push_back(code);
      if (code == 2'd0) foreach (ob[i]) exp_out.push_back(ob[i]);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((exp_ev.size() != 0 || exp_out.size() != 0 || out_valid) && k < 3000) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk(k < 3000, "idle_timeout", k, 3000);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input byte_q_t f);
      expect_frame(f);
      send(f);
      wait_idle();
   endtask

   initial begin
      byte_q_t good, f, ob;
      logic [1:0] c;
      logic [7:0] x;
      int k;

      n_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk({in_ready, out_valid, frame_ok, frame_err, err_code, err_cnt, out_data} == 22'd0, "reset_state",
          int'({in_ready, out_valid, frame_ok, frame_err, err_code, err_cnt, out_data}), 0);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      chk(in_ready == 1'b1, "ready_after_reset", int'(in_ready), 1);

      // Pin the model with hand-computed verdicts
      good = '{8'h05, 8'h02, 8'hAA, 8'h55};
`ifdef RX_GUARD_CHECKSUM_EN
      good.push_back(8'hF8);
`endif
      predict(good, c, ob);
      chk(c == 2'd0, "model_good_code", int'(c), 0);
      chk(ob.size() == 4 && ob[0] == 8'h05 && ob[1] == 8'h02 && ob[2] == 8'hAA && ob[3] == 8'h55,
          "model_good_bytes", ob.size(), 4);
      f = '{8'h1E, 8'h01, 8'h00};
`ifdef RX_GUARD_CHECKSUM_EN
      f.push_back(8'h1F);
`endif
      predict(f, c, ob);
      chk(c == 2'd1, "model_bad_addr_code", int'(c), 1);

      run_frame(good);
      chk(err_cnt == 8'd0, "good_err_cnt", int'(err_cnt), 0);

`ifdef RX_GUARD_CHECKSUM_EN
      f = '{8'h05, 8'h02, 8'hAA, 8'h55, 8'h00};
      predict(f, c, ob);
      chk(c == 2'd2, "model_bad_csum_code", int'(c), 2);
      run_frame(f);
      chk(err_code == 2'd2, "bad_csum_code", int'(err_code), 2);
      chk(err_cnt == 8'd1, "bad_csum_cnt", int'(err_cnt), 1);
`endif

      f = '{8'h1E, 8'h01, 8'h00};
`ifdef RX_GUARD_CHECKSUM_EN
      f.push_back(8'h1F);
`endif
      run_frame(f);
      chk(err_code == 2'd1, "bad_addr_code", int'(err_code), 1);

      // Address boundary (N_SRC is the first invalid value), zero length, maximum length
      f = '{8'h19, 8'h01, 8'h33};
`ifdef RX_GUARD_CHECKSUM_EN
      f.push_back(8'h2B);
`endif
      run_frame(f);
      f = '{8'h03, 8'h00};
`ifdef RX_GUARD_CHECKSUM_EN
      f.push_back(8'h03);
`endif
      run_frame(f);
      chk(err_code == 2'd1, "len0_code", int'(err_code), 1);
      f = '{8'h18, 8'hFF};
      x = 8'h18 ^ 8'hFF;
      for (int i = 0; i < 255; i++) begin
         f.push_back(8'(i));
         x ^= 8'(i);
      end
`ifdef RX_GUARD_CHECKSUM_EN
      f.push_back(x);
`endif
      run_frame(f);

      // Inter-byte timeout mid-payload
      f = '{8'h05, 8'h02, 8'hAA};
      exp_ev.push_back(2'd3);
      send(f);
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!frame_err && k < TO + 10);
      chk(k == TO, "timeout_cycles", k, TO);
      chk(err_code == 2'd3, "timeout_code", int'(err_code), 3);
      wait_idle();
      run_frame(good);

      // Downstream toggling backpressure
      bp_mode = 1'b1;
      f = '{8'h07, 8'h03, 8'h10, 8'h20, 8'h30};
`ifdef RX_GUARD_CHECKSUM_EN
      f.push_back(8'h04);
`endif
      run_frame(f);
      bp_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Error counter saturation
      f = '{8'h1E, 8'h01, 8'h00};
`ifdef RX_GUARD_CHECKSUM_EN
      f.push_back(8'h1F);
`endif
      for (int i = 0; i < 256; i++) begin
         expect_frame(f);
         send(f);
      end
      wait_idle();
      chk(err_cnt == 8'd255, "err_cnt_saturated", int'(err_cnt), 255);

      // Reset in the middle of the payload
      f = '{8'h05, 8'h04, 8'h11, 8'h22};
      send(f);
      n_rst = 1'b0;
      @(posedge clk);
      #1;
      chk({in_ready, out_valid, frame_ok, frame_err, err_code, err_cnt, out_data} == 22'd0, "mid_frame_reset",
          int'({in_ready, out_valid, frame_ok, frame_err, err_code, err_cnt, out_data}), 0);
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      chk(in_ready == 1'b1, "ready_after_mid_reset", int'(in_ready), 1);
      run_frame(good);
      chk(err_cnt == 8'd0, "err_cnt_after_reset", int'(err_cnt), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rx_frame_guard.md
RX_FRAME_GUARD -- requirements
Module: rx_frame_guard

Interface
REQ-001 The block SHALL have parameter N_SRC, default 25, giving the number of valid destination addresses (0..N_SRC-1).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 100000, giving the inter-byte timeout in clk cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; every register is clocked on its rising edge.
REQ-004 The block SHALL have port n_rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_data, input, 8 bits: byte from the UART receiver.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the byte.
REQ-008 The block SHALL have port out_data, output, 8 bits: byte to the command decoder.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the byte.
REQ-011 The block SHALL have port frame_ok, output, 1 bit: one-cycle pulse when a frame is accepted for forwarding.
REQ-012 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is discarded.
REQ-013 The block SHALL have port err_code, output, 2 bits: cause of the last discard (1 = bad address or len 0; 2 = checksum; 3 = timeout).
REQ-014 The block SHALL have port err_cnt, output, 8 bits: count of discarded frames, saturating at 255.

Function
REQ-015 Frame format SHALL be [addr][len][len payload bytes][csum]; len range 1..255.
REQ-016 A byte SHALL transfer on in_valid && in_ready, and likewise on out_valid && out_ready.
REQ-017 The state machine SHALL have states S_ADDR, S_LEN, S_PAY, S_CSUM, S_DRAIN; reset state S_ADDR.
REQ-018 States S_ADDR through S_CSUM SHALL hold in_ready = 1; S_DRAIN SHALL hold in_ready = 0.
REQ-019 Each accepted addr, len and payload byte SHALL be written into an internal 257-byte buffer and XORed into a running checksum, which clears on entry to S_ADDR.
REQ-020 An addr >= N_SRC or len == 0 SHALL set a bad flag; reception SHALL continue to the frame end, with len == 0 going S_LEN -> S_CSUM.
REQ-021 At the frame end, if the bad flag is clear and the checksum matches, the block SHALL pulse frame_ok and enter S_DRAIN the next cycle.
REQ-022 At the frame end otherwise, the block SHALL pulse frame_err, set err_code (1 takes priority over 2), increment err_cnt, and return to S_ADDR.
REQ-023 In S_DRAIN the block SHALL emit the addr, len and payload bytes in order; the csum byte SHALL NOT be emitted.
REQ-024 The first out_valid SHALL assert no later than 2 cycles after frame_ok.
REQ-025 out_data SHALL hold stable while out_valid && !out_ready.
REQ-026 After the last byte transfers, out_valid SHALL drop and the block SHALL enter S_ADDR.
REQ-027 A timeout counter SHALL increment each cycle in S_LEN, S_PAY or S_CSUM without an accepted byte, and clear on every accepted byte.
REQ-028 When the timeout counter reaches TIMEOUT_CYC, the block SHALL discard the partial frame with err_code = 3 and return to S_ADDR.
REQ-029 Timeout SHALL NOT apply in S_ADDR or S_DRAIN; S_DRAIN backpressure is unlimited.
REQ-030 frame_ok and frame_err SHALL never assert in the same cycle.

Reset
REQ-031 When n_rst = 0 at a clk edge, the block SHALL go to S_ADDR and clear in_ready, out_valid, frame_ok, frame_err, err_code, err_cnt, the checksum and all counters; out_data SHALL be 0.
REQ-032 Reset asserted mid-reception or mid-drain SHALL abandon the frame with no pulse, and in_ready SHALL return to 1 in the first cycle after reset release.

Configuration
REQ-033 With RX_GUARD_CHECKSUM_EN defined, the block SHALL expect and verify the csum byte as specified above.
REQ-034 Without RX_GUARD_CHECKSUM_EN, the frame SHALL be [addr][len][payload], S_CSUM SHALL be absent, and err_code 2 SHALL never occur.
REQ-035 Without RX_GUARD_CHECKSUM_EN, a len == 0 frame SHALL end after the len byte.

Verification (RX_GUARD_CHECKSUM_EN defined, N_SRC = 25)
REQ-036 Good frame: input 05 02 AA 55 F8 with out_ready = 1 -> frame_ok pulse, then output 05 02 AA 55, err_cnt = 0.
REQ-037 Bad checksum: input 05 02 AA 55 00 -> frame_err, err_code = 2, err_cnt = 1, no out_valid.
REQ-038 Bad address: input 1E 01 00 1F -> frame_err, err_code = 1, no output.
REQ-039 Timeout: input 05 02 AA, then idle TIMEOUT_CYC cycles -> frame_err, err_code = 3; a following good frame is forwarded intact.
REQ-040 Backpressure: good frame with out_ready toggling 1/0 each cycle -> every byte is delivered once, data is stable while stalled, and in_ready = 0 until the drain completes.
REQ-041 Saturation and reset: 256 bad frames -> err_cnt = 255; then n_rst pulsed during S_PAY -> all outputs 0 and no pulse.
